// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: state encoding, clause 22 frame constants and frame builder for the MDIO master
package eth_mdio_pkg;
  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} mdio_state_t;
  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam int MDIO_CMD_BITS = 14;
  localparam int MDIO_DATA_BITS = 16;
  // Read frames leave TA/DATA as ones; the line is released there anyway
  function automatic logic [31:0] mdio_frame(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] wdata);
    return wr ? {MDIO_ST, MDIO_OP_WR, phy, regad, 2'b10, wdata}
              : {MDIO_ST, MDIO_OP_RD, phy, regad, 18'h3ffff};
  endfunction
endpackage

// File: rtl/eth_mdio_clkgen.sv
// eth_mdio_clkgen: MDC generator with per-bit strobes, held in the low phase while disabled
import eth_mdio_pkg::*;
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 20
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  output logic o_mdc,
  output logic o_bit_start,
  output logic o_sample,
  output logic o_bit_end
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] r_cnt;
  logic          r_ph;
  always_ff @(posedge i_clk)
    if (!i_rstn || !i_en) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_ph  <= ~r_ph;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  assign o_mdc       = r_ph;
  assign o_bit_start = i_en & ~r_ph & (r_cnt == '0);
  assign o_sample    = i_en & ~r_ph & (r_cnt == LAST);
  assign o_bit_end   = i_en &  r_ph & (r_cnt == LAST);
endmodule

// File: rtl/eth_mdio_ctrl.sv
// eth_mdio_ctrl: clause 22 MDIO management master, one request at a time.
// ETH_MDIO_PRE_SUPPRESS_EN adds req_no_pre to skip the preamble.
import eth_mdio_pkg::*;
module eth_mdio_ctrl #(
  parameter int CLK_DIV  = 20,
  parameter int PRE_BITS = 32
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
  input  logic        req_no_pre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_emdc,
  input  logic        i_emdio,
  output logic        o_emdio,
  output logic        oe_emdio
);
  localparam int FW = PRE_BITS + 32;
  mdio_state_t   r_state;
  logic [5:0]    r_bcnt;
  logic [FW-2:0] r_sh;
  logic          r_write;
  logic [31:0]   w_frm;
  logic [FW-1:0] w_load;
  mdio_state_t   w_next;
  logic [5:0]    w_reload;
  logic          w_en, w_start, w_sample, w_end, w_skip, w_last, w_accept;
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
  assign w_skip = req_no_pre;
`else
  assign w_skip = 1'b0;
`endif
  assign req_ready = r_state == IDLE;
  assign w_accept  = req_valid & req_ready;
  assign w_en      = r_state inside {PRE, CMD, TA, DATA};
  assign w_last    = r_bcnt == 6'd0;
  assign w_frm     = mdio_frame(req_write, req_phy_addr, req_reg_addr, req_wdata);
  // Whole frame as one shift image; suppression puts the preamble ones behind the frame
  assign w_load    = w_skip ? {w_frm, {PRE_BITS{1'b1}}} : {{PRE_BITS{1'b1}}, w_frm};
  assign w_next    = r_state == PRE ? CMD : r_state == CMD ? TA : r_state == TA ? DATA : DONE;
  assign w_reload  = w_next == CMD ? 6'(MDIO_CMD_BITS - 1) : w_next == TA ? 6'd1 : 6'(MDIO_DATA_BITS - 1);
  eth_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .i_clk       (msoc_clk),
    .i_rstn      (rstn),
    .i_en        (w_en),
    .o_mdc       (o_emdc),
    .o_bit_start (w_start),
    .o_sample    (w_sample),
    .o_bit_end   (w_end)
  );
  // Pin values are loaded at the edge ending the previous bit so they are valid on its first low cycle
  always_ff @(posedge msoc_clk)
    if (!rstn) begin
      r_state   <= IDLE;
      r_bcnt    <= '0;
      r_sh      <= '0;
      r_write   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      o_emdio   <= 1'b1;
      oe_emdio  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state   <= w_skip ? CMD : PRE;
          r_bcnt    <= w_skip ? 6'(MDIO_CMD_BITS - 1) : 6'(PRE_BITS - 1);
          r_sh      <= w_load[FW-2:0];
          o_emdio   <= w_load[FW-1];
          oe_emdio  <= 1'b1;
          r_write   <= req_write;
          busy      <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          if (w_sample && !r_write && r_state == TA && w_last) rsp_err <= i_emdio;
          if (w_sample && !r_write && r_state == DATA) rsp_rdata <= {rsp_rdata[14:0], i_emdio};
          if (w_end) begin
            r_sh    <= {r_sh[FW-3:0], 1'b1};
            r_bcnt  <= w_last ? w_reload : r_bcnt - 6'd1;
            o_emdio <= (w_last && w_next == DONE) | r_sh[FW-2];
            if (w_last) r_state <= w_next;
            if (w_last && (w_next == DONE || (w_next == TA && !r_write))) oe_emdio <= 1'b0;
            if (w_last && w_next == DONE) rsp_valid <= 1'b1;
          end
        end
      endcase
    end
  a_pre_ones: assert property (@(posedge msoc_clk) disable iff (!rstn)
    (w_start && r_state == PRE) |-> (o_emdio && oe_emdio));
endmodule

// File: doc/eth_mdio_ctrl.md
Name: eth_mdio_ctrl

Overview:
- Hardware MDIO (IEEE 802.3 clause 22) management master for the Ethernet PHY.
- Replaces software bit-banging of the MDC/MDIO pins.
- Accepts one read or write request at a time, serialises the full management frame on MDC/MDIO, and returns read data with a one-cycle response pulse.
- Sits in the msoc_clk domain beside the framing block's register file; drives the PHY pins o_emdc/o_emdio/oe_emdio directly.

Parameters:
- CLK_DIV, 20: msoc_clk cycles per MDC half-period. MDC period = 2*CLK_DIV. Legal range 1..255.
- PRE_BITS, 32: preamble length in bits, all ones.

Ports:
- msoc_clk  in  1  system clock.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_phy_addr  in  5  PHY address.
- req_reg_addr  in  5  register address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data; 0 for writes.
- rsp_err  out  1  read turnaround bit not driven low by the PHY.
- busy  out  1  transaction in progress (includes DONE).
- o_emdc  out  1  MDC.
- i_emdio  in  1  MDIO from the pad.
- o_emdio  out  1  MDIO drive value.
- oe_emdio  out  1  MDIO output enable.

Behaviour:
- Reset values: o_emdc=0, o_emdio=1, oe_emdio=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE. req_ready is therefore 1 on the cycle after reset.
- Handshake: a request is accepted on a cycle with req_valid & req_ready. All request fields are latched on that cycle. req_valid is ignored in every other state.
- Frame, MSB first, in this order:
  - PRE_BITS ones.
  - ST=01.
  - OP: write 01, read 10.
  - PHYAD[4:0], then REGAD[4:0].
  - TA: write drives 1,0; read releases the line.
  - DATA[15:0].
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles: low phase of CLK_DIV cycles (o_emdc=0), then high phase of CLK_DIV cycles (o_emdc=1).
  - o_emdio/oe_emdio change only on the first cycle of a low phase.
  - i_emdio is sampled on the last cycle of the low phase, i.e. the cycle before MDC rises.
- FSM states:
  - IDLE: req_ready=1, oe_emdio=0, o_emdio=1, o_emdc=0.
  - PRE: PRE_BITS bits.
  - CMD: 14 bits (ST, OP, PHYAD, REGAD).
  - TA: 2 bits.
  - DATA: 16 bits.
  - DONE: one cycle; rsp_valid=1, oe_emdio=0; then IDLE.
- Output enable: oe_emdio=1 through PRE, CMD, TA and DATA for a write. For a read, oe_emdio=1 through PRE and CMD, and 0 from the start of TA to the end.
- Read sampling:
  - Second TA bit: a sampled 1 sets rsp_err.
  - DATA bits shift into rsp_rdata, MSB first.
  - rsp_rdata/rsp_err are cleared at accept and hold their value after DONE until the next accept.
- Latency:
  - Accept at cycle 0; the first bit starts at cycle 1.
  - The last bit ends at cycle (PRE_BITS+32)*2*CLK_DIV.
  - rsp_valid is asserted on the following cycle. Default: cycle 2561.
- busy=1 from the cycle after accept through DONE inclusive. The earliest next accept is the cycle after rsp_valid.
- Counters:
  - Divider counter width is $clog2(CLK_DIV+1).
  - Bit counter is 6 bits and is reloaded on every state entry.
  - No wrap occurs within a frame.
- rstn low mid-frame: IDLE reset values on the next edge; no rsp_valid is generated.

Optional Feature:
- Macro: ETH_MDIO_PRE_SUPPRESS_EN.
- When defined:
  - Adds input req_no_pre (1 bit), latched at accept.
  - If set, PRE is skipped: CMD starts at cycle 1 and rsp_valid is asserted at cycle 32*2*CLK_DIV+1. This is PHY preamble suppression.
- When undefined:
  - The port does not exist and the preamble is always sent.

Decomposition:
- Package eth_mdio_pkg:
  - State enum (IDLE, PRE, CMD, TA, DATA, DONE).
  - Constants MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, MDIO_CMD_BITS=14, MDIO_DATA_BITS=16.
- Sub-module eth_mdio_clkgen (parameter CLK_DIV):
  - Free-runs only when enabled.
  - Outputs mdc, bit_start (first low-phase cycle), sample (last low-phase cycle) and bit_end.
  - The FSM consumes these strobes.

Test Plan:
- Write, CLK_DIV=2, phy=5'h01, reg=5'h00, wdata=16'h1140 -> MDIO carries 32 ones, then 01 01 00001 00000 10 0001000101000000. oe_emdio is high throughout. rsp_valid is high at cycle 257 only; rsp_err=0; rsp_rdata=0.
- Read, CLK_DIV=2, phy=5'h01, reg=5'h02, PHY model drives TA 0 then 16'h7949 -> oe_emdio=0 from TA onward; rsp_rdata=16'h7949; rsp_err=0.
- Read with no PHY (i_emdio held 1) -> rsp_err=1 and rsp_rdata=16'hFFFF at rsp_valid.
- req_valid held high for two requests -> second accept on the cycle after rsp_valid; req_ready=0 and busy=1 throughout the first transaction.
- rstn pulsed low during bit 40 of a write -> next cycle o_emdc=0, o_emdio=1, oe_emdio=0, busy=0, req_ready=1; no rsp_valid ever.
- With ETH_MDIO_PRE_SUPPRESS_EN and req_no_pre=1, CLK_DIV=2 -> no preamble on MDIO; rsp_valid at cycle 129.
